leaf_stream_buffer: RTL

Parametrised bank of independent first-word-fall-through stream FIFOs that sits between the leaf_interface user-side ports and an HLS operator inside a leaf wrapper, one FIFO per direction-channel. It generalises the fixed three-port, unbuffered leaf wiring. It adds these features:
- configurable channel count, payload width and depth
- per-channel occupancy and almost-full reporting
- a synchronous flush for reconfiguration of the page.

---
 rtl/leaf_stream_buffer.sv | 84 ++++++++
 1 files changed

// File: rtl/leaf_stream_buffer.sv
// Bank of independent first-word-fall-through stream FIFOs between the leaf
// interface ports and an HLS operator; one FIFO per channel with flush.
module leaf_stream_buffer #(
  parameter int NUM_CH       = 3,
  parameter int PAYLOAD_BITS = 32,
  parameter int DEPTH_BITS   = 4,
  parameter int AF_MARGIN    = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [NUM_CH*PAYLOAD_BITS-1:0]     din,
  input  logic [NUM_CH-1:0]                  vld_in,
  output logic [NUM_CH-1:0]                  ack_out,
  output logic [NUM_CH*PAYLOAD_BITS-1:0]     dout,
  output logic [NUM_CH-1:0]                  vld_out,
  input  logic [NUM_CH-1:0]                  ack_in,
  output logic [NUM_CH*(DEPTH_BITS+1)-1:0]   count,
  output logic [NUM_CH-1:0]                  almost_full
);

  localparam int PW    = DEPTH_BITS + 1;
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
  localparam logic [PW-1:0] AF_V    = PW'(AF_MARGIN);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : gen_ch
      logic [PAYLOAD_BITS-1:0] mem_reg [DEPTH];
      logic [PW-1:0]           wr_ptr_reg, wr_ptr_next;
      logic [PW-1:0]           rd_ptr_reg, rd_ptr_next;
      logic [PW-1:0]           occ;
      logic [PW-1:0]           free;
      logic                    full, empty, push, pop;

      // The extra pointer MSB lets a plain subtraction separate full from empty.
      assign occ   = wr_ptr_reg - rd_ptr_reg;
      assign free  = DEPTH_V - occ;
      assign full  = (occ == DEPTH_V);
      assign empty = (occ == '0);

      // Handshakes are qualified only by registered state, so ack_out never
      // depends combinationally on ack_in.
      assign push = vld_in[gi] && !full;
      assign pop  = ack_in[gi] && !empty;

      always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
          wr_ptr_next = '0;
          rd_ptr_next = '0;
        end else begin
          if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
          if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          wr_ptr_reg <= wr_ptr_next;
          rd_ptr_reg <= rd_ptr_next;
        end
      end

      // Storage is deliberately left out of reset and flush.
      always_ff @(posedge clk) begin
        if (push && !flush)
          mem_reg[wr_ptr_reg[DEPTH_BITS-1:0]] <= din[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
      end

      assign dout[gi*PAYLOAD_BITS +: PAYLOAD_BITS] = mem_reg[rd_ptr_reg[DEPTH_BITS-1:0]];
      assign vld_out[gi]                          = !empty;
      assign ack_out[gi]                          = !full;
      assign count[gi*PW +: PW]                   = occ;
      assign almost_full[gi]                      = (free <= AF_V);
    end
  endgenerate

endmodule
